mem_fifo_ctrl: RTL and testbench

FIFO controller that sits directly upstream of the 16 x 8 single-address-port memory blocks. It owns the memory's `read`, `write`, `addr` and `data_in` pins and captures its `data_out`. It presents valid/ready streaming interfaces on both sides, so the memory behaves as a 16-deep FIFO. The memory has one address bus, so the controller grants at most one memory operation per cycle and arbitrates push against pop.

---
 rtl/mem_fifo_ctrl.sv | 120 ++++++++++++
 tb/tb_mem_fifo_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fifo_ctrl.sv
// mem_fifo_ctrl
//   Turns a 16 x 8 single-address-port memory into a 16-deep streaming FIFO.
//   The memory has one address bus, so the controller grants at most one
//   memory operation per cycle. When a push and a pop both want the bus in
//   the same cycle, the grant alternates between them (round-robin).
//
// Parameters
//   DW : data width (must match the memory)
//   AW : address width, depth = 2**AW
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : upstream handshake, in_data is the pushed word
//   out_valid/out_ready   : downstream handshake, out_data is the registered head
//   mem_read, mem_write   : registered memory strobes (never both high)
//   mem_addr, mem_data_in : registered memory address / write data
//   mem_data_out          : memory read data, sampled while a read is in flight
//
// Optional feature (macro MEM_FIFO_CTRL_LEVEL_EN)
//   Adds output `level` [AW:0] = occ + rd_inflight + out_valid, registered.
//   When the macro is undefined the port and its logic are absent.

module mem_fifo_ctrl #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out
`ifdef MEM_FIFO_CTRL_LEVEL_EN
  ,
  output logic [AW:0]   level
`endif
);

  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);
  localparam logic [0:0]  LG_RD = 1'b0;
  localparam logic [0:0]  LG_WR = 1'b1;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;
  logic          rd_inflight;
  logic [0:0]    last_gnt;

  logic wr_elig, rd_elig, wr_gnt, rd_gnt;

  // A read needs a free output slot by the time its data returns: the slot
  // is free if it is empty now or is being consumed this cycle. Only one read
  // may be outstanding, which caps pops at one every two cycles.
  always_comb begin
    wr_elig = in_valid && (occ < DEPTH);
    rd_elig = (occ != '0) && !rd_inflight && (!out_valid || out_ready);
    wr_gnt  = wr_elig && (!rd_elig || (last_gnt == LG_RD));
    rd_gnt  = rd_elig && (!wr_elig || (last_gnt == LG_WR));
  end

  assign in_ready = wr_gnt && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      rd_inflight <= 1'b0;
      last_gnt    <= LG_RD;
      out_valid   <= 1'b0;
      out_data    <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
    end else begin
      mem_write   <= wr_gnt;
      mem_read    <= rd_gnt;
      rd_inflight <= rd_gnt;

      if (wr_gnt) begin
        mem_addr    <= wr_ptr;
        mem_data_in <= in_data;
        wr_ptr      <= wr_ptr + 1'b1;
        occ         <= occ + 1'b1;
        last_gnt    <= LG_WR;
      end else if (rd_gnt) begin
        mem_addr    <= rd_ptr;
        rd_ptr      <= rd_ptr + 1'b1;
        occ         <= occ - 1'b1;
        last_gnt    <= LG_RD;
      end

      // Memory data is valid during the cycle the strobe is high; a capture
      // wins over a same-cycle consume, since the slot was freed to take it.
      if (rd_inflight) begin
        out_data  <= mem_data_out;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MEM_FIFO_CTRL_LEVEL_EN
  // Words held anywhere in the controller: stored, returning from memory,
  // or waiting in the output register.
  always_ff @(posedge clk) begin
    if (rst) level <= '0;
    else     level <= occ + {{AW{1'b0}}, rd_inflight} + {{AW{1'b0}}, out_valid};
  end
`endif

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Bench for mem_fifo_ctrl: directed scenarios plus a randomized run, all
// compared against a queue-based reference model of the FIFO controller.
module tb_mem_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid, out_ready = 1'b0;
  logic [7:0] out_data;
  logic       mem_read, mem_write;
  logic [3:0] mem_addr;
  logic [7:0] mem_data_in, mem_data_out;
`ifdef MEM_FIFO_CTRL_LEVEL_EN
  logic [4:0] level;
`endif

  always #5 clk = ~clk;

  mem_fifo_ctrl #(.DW(8), .AW(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
`ifdef MEM_FIFO_CTRL_LEVEL_EN
    , .level(level)
`endif
  );

  // 16 x 8 memory: synchronous write, combinational read
  logic [7:0] mem [16];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_data_in;
  assign mem_data_out = mem[mem_addr];

  int checks = 0, fails = 0;
  int accepted = 0, pops = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, the output register, and the
  // word currently returning from memory.
  logic [7:0] m_q[$];
  logic [7:0] sb[$];
  int   m_wp, m_rp, m_lvl;
  bit   m_inf, m_ov, m_last_wr, m_mr, m_mw;
  logic [7:0] m_inf_w, m_od, m_md;
  logic [3:0] m_ma;

  task automatic model_reset();
    m_q.delete(); sb.delete();
    m_wp = 0; m_rp = 0; m_lvl = 0;
    m_inf = 0; m_ov = 0; m_last_wr = 0; m_mr = 0; m_mw = 0;
    m_inf_w = 0; m_od = 0; m_md = 0; m_ma = 0;
  endtask

  task automatic grants(input bit iv, input bit ordy, output bit wg, output bit rg);
    bit we, re;
    we = iv && (m_q.size() < 16);
    re = (m_q.size() > 0) && !m_inf && (!m_ov || ordy);
    wg = we && (!re || m_last_wr == 0);
    rg = re && (!we || m_last_wr == 1);
  endtask

  task automatic model_tick(input bit wg, input bit rg, input bit ordy, input logic [7:0] d);
    int nl;
    nl = m_q.size() + int'(m_inf) + int'(m_ov);
    if (m_inf) begin m_ov = 1; m_od = m_inf_w; end
    else if (ordy) m_ov = 0;
    m_mw = wg; m_mr = rg; m_inf = rg;
    if (wg) begin
      m_ma = m_wp[3:0]; m_md = d; m_wp = (m_wp + 1) % 16;
      m_q.push_back(d); sb.push_back(d); m_last_wr = 1;
    end else if (rg) begin
      m_ma = m_rp[3:0]; m_rp = (m_rp + 1) % 16;
      m_inf_w = m_q.pop_front(); m_last_wr = 0;
    end
    m_lvl = nl;
  endtask

  // One clock cycle: drive at negedge, check 1 time unit later, advance model.
  task automatic step(input bit r, input bit iv, input logic [7:0] d, input bit ordy);
    bit wg, rg;
    @(negedge clk);
    rst = r; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    grants(iv, ordy, wg, rg);
    chk("in_ready", in_ready, r ? 1'b0 : wg);
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_od);
    chk("mem_write", mem_write, m_mw);
    chk("mem_read", mem_read, m_mr);
    chk("mem_addr", mem_addr, m_ma);
    chk("mem_data_in", mem_data_in, m_md);
    chk("rw_excl", mem_read && mem_write, 1'b0);
    chk("occ", dut.occ, m_q.size());
`ifdef MEM_FIFO_CTRL_LEVEL_EN
    chk("level", level, m_lvl);
`endif
    if (r) begin
      model_reset();
    end else begin
      if (out_valid && ordy) begin
        pops++;
        if (sb.size() == 0) chk("pop_empty", 1'b1, 1'b0);
        else chk("pop_order", out_data, sb.pop_front());
      end
      if (wg) accepted++;
      model_tick(wg, rg, ordy, d);
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, ordy);
  endtask

  initial begin
    bit prev_w;
    int budget;
    model_reset();
    repeat (2) @(posedge clk);
    step(1, 1, 8'h55, 1);                 // reset state, in_ready low in reset

    // single push of A5 into an empty controller
    step(0, 1, 8'hA5, 0);
    step(0, 0, 8'h00, 0);
    chk("a5_wr", {mem_write, mem_addr, mem_data_in}, {1'b1, 4'h0, 8'hA5});
    step(0, 0, 8'h00, 0);
    chk("a5_rd", {mem_read, mem_addr}, {1'b1, 4'h0});
    step(0, 0, 8'h00, 0);
    chk("a5_out", {out_valid, out_data}, {1'b1, 8'hA5});
    idle(3, 1);
    step(1, 0, 8'h00, 0);

    // fill with out_ready low: 17 words accepted, then full
    accepted = 0; pops = 0; budget = 0;
    while (accepted < 17 && budget < 100) begin
      step(0, 1, 8'(accepted), 0);
      budget++;
    end
    chk("fill_cnt", accepted, 17);
    step(0, 0, 8'h00, 0);
    chk("wrap_wr", {mem_write, mem_addr}, {1'b1, 4'h0});
    idle(3, 0);
    step(0, 1, 8'hEE, 0);
    chk("full_rdy", in_ready, 1'b0);
    chk("full_occ", dut.occ, 16);

    // drain
    idle(60, 1);
    chk("drain_cnt", pops, 17);
    chk("drain_ov", out_valid, 1'b0);

    // contention at occ=4
    accepted = 0; budget = 0;
    while (accepted < 5 && budget < 40) begin
      step(0, 1, 8'(8'h40 + accepted), 0);
      budget++;
    end
    idle(4, 0);
    chk("cont_occ", dut.occ, 4);
    for (int i = 0; i < 24; i++) begin
      prev_w = mem_write;
      step(0, 1, 8'($urandom), 1);
      if (i >= 2) begin
        chk("alt", mem_write, !prev_w);
        chk("occ_rng", (dut.occ >= 3) && (dut.occ <= 5), 1'b1);
      end
    end
    idle(40, 1);

    // reset while a read is in flight
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h11, 0);
    step(0, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);                 // mem_read high this cycle
    chk("rst_inflight", dut.rd_inflight, 1'b1);
    step(0, 0, 8'h00, 0);
    chk("rst_outs", {out_valid, mem_read, mem_write, mem_addr, mem_data_in, out_data}, 0);
    idle(3, 0);
    chk("rst_ov", out_valid, 1'b0);
    step(0, 1, 8'h3C, 0);
    step(0, 0, 8'h00, 0);
    chk("3c_wr", {mem_write, mem_addr, mem_data_in}, {1'b1, 4'h0, 8'h3C});
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    chk("3c_out", {out_valid, out_data}, {1'b1, 8'h3C});

`ifdef MEM_FIFO_CTRL_LEVEL_EN
    step(1, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    chk("lvl_rst", level, 0);
    accepted = 0; budget = 0;
    while (accepted < 3 && budget < 20) begin
      step(0, 1, 8'(8'h70 + accepted), 0);
      budget++;
    end
    idle(4, 0);
    chk("lvl_3", level, 3);
`endif

    // randomized traffic with occasional resets
    for (int blk = 0; blk < 8; blk++) begin
      int pv, pr;
      pv = $urandom_range(1, 9);
      pr = $urandom_range(1, 9);
      for (int i = 0; i < 100; i++)
        step($urandom_range(0, 149) == 0, $urandom_range(0, 9) < pv,
             8'($urandom), $urandom_range(0, 9) < pr);
    end
    idle(50, 1);
    chk("final_empty", sb.size(), 0);
    chk("final_ov", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
